// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if
//   Groups the sweep configuration/command inputs and the sweep outputs of
//   dds_sweep_ctrl into one bundle. clk, reset_n and clken stay plain ports
//   on the controller.
//
//   start, abort          : command strobes (level, qualified by clken)
//   f_start, f_step       : initial phase increment / signed step
//   n_steps, dwell, mode  : sweep length, hold per frequency minus 1, sweep kind
//   phi_inc_o             : phase increment toward the NCO
//   busy, done, step_tick : sweep status
//
//   master : the side that configures and launches sweeps
//   slave  : the sweep controller
interface dds_sweep_ctrl_if #(
  parameter int apr = 48,
  parameter int stw = 32,
  parameter int cnw = 24,
  parameter int dww = 16
);
  logic                  start;
  logic                  abort;
  logic        [apr-1:0] f_start;
  logic signed [stw-1:0] f_step;
  logic        [cnw-1:0] n_steps;
  logic        [dww-1:0] dwell;
  logic        [1:0]     mode;
  logic        [apr-1:0] phi_inc_o;
  logic                  busy;
  logic                  done;
  logic                  step_tick;

  modport master (
    output start, abort, f_start, f_step, n_steps, dwell, mode,
    input  phi_inc_o, busy, done, step_tick
  );

  modport slave (
    input  start, abort, f_start, f_step, n_steps, dwell, mode,
    output phi_inc_o, busy, done, step_tick
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//   Stepped linear frequency-sweep (chirp) generator feeding the NCO phase
//   increment. Supports single-shot, repeating sawtooth and up/down triangle
//   sweeps, each frequency held for dwell+1 clken cycles.
//
//   clk     : NCO clock
//   reset_n : asynchronous active-low reset
//   clken   : NCO sample enable; all sweep state advances only when high
//   bus     : dds_sweep_ctrl_if.slave (commands, configuration, outputs)
module dds_sweep_ctrl #(
  parameter int apr = 48,
  parameter int stw = 32,
  parameter int cnw = 24,
  parameter int dww = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic {IDLE, DWELL} state_t;

  localparam logic [cnw-1:0] STEP_ONE  = cnw'(1);
  localparam logic [dww-1:0] DWELL_ONE = dww'(1);

  state_t                state;
  logic        [cnw-1:0] step_cnt;
  logic        [dww-1:0] dwell_cnt;
  logic                  dir_down;

  // Configuration captured at start so the bus may change mid-sweep.
  logic        [apr-1:0] f_start_s;
  logic signed [stw-1:0] f_step_s;
  logic        [cnw-1:0] n_steps_s;
  logic        [dww-1:0] dwell_s;
  logic        [1:0]     mode_s;

  logic        [apr-1:0] phi;
  logic                  busy_r;
  logic                  done_r;
  logic                  tick_r;

  // Sign-extend the step to the accumulator width.
  function automatic logic signed [apr-1:0] sext_step(input logic signed [stw-1:0] s);
    return {{(apr-stw){s[stw-1]}}, s};
  endfunction

  // Modulo-2^apr step; the sweep is allowed to wrap, never saturates.
  function automatic logic [apr-1:0] wrap_step(input logic [apr-1:0] p,
                                               input logic signed [apr-1:0] d,
                                               input logic down);
    logic [apr-1:0] du;
    du = $unsigned(d);
    return down ? (p - du) : (p + du);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      step_cnt  <= '0;
      dwell_cnt <= '0;
      dir_down  <= 1'b0;
      f_start_s <= '0;
      f_step_s  <= '0;
      n_steps_s <= '0;
      dwell_s   <= '0;
      mode_s    <= '0;
      phi       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      // Pulses last one clk, even when clken is low on the next edge.
      done_r <= 1'b0;
      tick_r <= 1'b0;
      if (clken) begin
        if (bus.abort) begin
          // Abort wins over start and over any pending step; output holds.
          state  <= IDLE;
          busy_r <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (bus.start) begin
                f_start_s <= bus.f_start;
                f_step_s  <= bus.f_step;
                n_steps_s <= bus.n_steps;
                dwell_s   <= bus.dwell;
                mode_s    <= bus.mode;
                phi       <= bus.f_start;
                dwell_cnt <= bus.dwell;
                step_cnt  <= '0;
                dir_down  <= 1'b0;
                busy_r    <= 1'b1;
                state     <= DWELL;
              end
            end
            DWELL: begin
              if (dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - DWELL_ONE;
              end else if (step_cnt != n_steps_s) begin
                phi       <= wrap_step(phi, sext_step(f_step_s), dir_down);
                step_cnt  <= step_cnt + STEP_ONE;
                dwell_cnt <= dwell_s;
                tick_r    <= 1'b1;
              end else begin
                case (mode_s)
                  2'd1: begin
                    // Sawtooth: jump back to the start frequency.
                    phi       <= f_start_s;
                    step_cnt  <= '0;
                    dwell_cnt <= dwell_s;
                    tick_r    <= 1'b1;
                  end
                  2'd2: begin
                    // Triangle: reverse direction and hold the end point
                    // for a second dwell, so no tick here.
                    dir_down  <= ~dir_down;
                    step_cnt  <= '0;
                    dwell_cnt <= dwell_s;
                  end
                  default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                  end
                endcase
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.phi_inc_o = phi;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.step_tick = tick_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;
  localparam int APR = 48;
  localparam int STW = 32;
  localparam int CNW = 24;
  localparam int DWW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b0;

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.apr(APR), .stw(STW), .cnw(CNW), .dww(DWW)) bus();

  dds_sweep_ctrl #(.apr(APR), .stw(STW), .cnw(CNW), .dww(DWW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        clken;
    logic        start;
    logic        abort;
    logic        scr;    // scramble the config bus after this edge
    logic [47:0] phi;
    logic        busy;
    logic        done;
    logic        tick;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ck, input logic st, input logic ab, input logic sc,
                     input logic [47:0] ph, input logic bz, input logic dn, input logic tk);
    vec_t v;
    v.clken = ck; v.start = st; v.abort = ab; v.scr = sc;
    v.phi = ph; v.busy = bz; v.done = dn; v.tick = tk;
    vecs.push_back(v);
  endtask

  task automatic cfg(input logic [47:0] fs, input logic [31:0] stp, input logic [23:0] n,
                     input logic [15:0] dw, input logic [1:0] md);
    bus.f_start = fs;
    bus.f_step  = stp;
    bus.n_steps = n;
    bus.dwell   = dw;
    bus.mode    = md;
  endtask

  task automatic check_outs(input string nm, input logic [47:0] ph, input logic bz,
                            input logic dn, input logic tk);
    chk({nm, ".phi"},  bus.phi_inc_o, ph);
    chk({nm, ".busy"}, {47'd0, bus.busy}, {47'd0, bz});
    chk({nm, ".done"}, {47'd0, bus.done}, {47'd0, dn});
    chk({nm, ".tick"}, {47'd0, bus.step_tick}, {47'd0, tk});
  endtask

  // Apply one vector per clk edge, check just after that edge.
  task automatic run(input string nm);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clken     = vecs[i].clken;
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      @(posedge clk);
      #1;
      check_outs($sformatf("%s[%0d]", nm, i), vecs[i].phi, vecs[i].busy,
                 vecs[i].done, vecs[i].tick);
      if (vecs[i].scr) cfg(48'hDEAD_BEEF_0000, 32'h7FFF_0000, 24'd9, 16'd5, 2'd2);
    end
    vecs.delete();
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clken     = 1'b1;
  endtask

  // Single sweep, start held high throughout the sweep (ignored while busy).
  task automatic load_single;
    add(1,1,0,1, 48'h1000, 1,0,0);  // e0
    add(1,1,0,0, 48'h1000, 1,0,0);  // e1
    add(1,1,0,0, 48'h1010, 1,0,1);  // e2
    add(1,1,0,0, 48'h1010, 1,0,0);  // e3
    add(1,1,0,0, 48'h1020, 1,0,1);  // e4
    add(1,1,0,0, 48'h1020, 1,0,0);  // e5
    add(1,1,0,0, 48'h1030, 1,0,1);  // e6
    add(1,1,0,0, 48'h1030, 1,0,0);  // e7
    add(1,0,0,0, 48'h1030, 0,1,0);  // e8 done
    add(1,0,0,0, 48'h1030, 0,0,0);  // e9
  endtask

  initial begin
    bus.start = 1'b1;
    bus.abort = 1'b0;
    clken     = 1'b1;
    cfg(48'h1000, 32'h10, 24'd3, 16'd1, 2'd0);

    // Reset state, with start and clken active during reset.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 48'h0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    reset_n   = 1'b1;

    // Single sweep.
    cfg(48'h1000, 32'h10, 24'd3, 16'd1, 2'd0);
    load_single();
    run("single");

    // Negative step wrapping below zero.
    cfg(48'h5, 32'hFFFF_FFF8, 24'd1, 16'd0, 2'd0);
    add(1,1,0,0, 48'h5, 1,0,0);
    add(1,0,0,0, 48'hFFFF_FFFF_FFFD, 1,0,1);
    add(1,0,0,0, 48'hFFFF_FFFF_FFFD, 0,1,0);
    add(1,0,0,0, 48'hFFFF_FFFF_FFFD, 0,0,0);
    run("negwrap");

    // Triangle; ended by abort (holds the value, no done).
    cfg(48'h100, 32'h1, 24'd2, 16'd0, 2'd2);
    add(1,1,0,0, 48'h100, 1,0,0);
    add(1,0,0,0, 48'h101, 1,0,1);
    add(1,0,0,0, 48'h102, 1,0,1);
    add(1,0,0,0, 48'h102, 1,0,0);
    add(1,0,0,0, 48'h101, 1,0,1);
    add(1,0,0,0, 48'h100, 1,0,1);
    add(1,0,0,0, 48'h100, 1,0,0);
    add(1,0,0,0, 48'h101, 1,0,1);
    add(1,0,0,0, 48'h102, 1,0,1);
    add(1,0,1,0, 48'h102, 0,0,0);
    run("tri");

    // Sawtooth repeat; f_start shadow must survive bus scrambling.
    cfg(48'h10, 32'h4, 24'd1, 16'd0, 2'd1);
    add(1,1,0,1, 48'h10, 1,0,0);
    add(1,0,0,0, 48'h14, 1,0,1);
    add(1,0,0,0, 48'h10, 1,0,1);
    add(1,0,0,0, 48'h14, 1,0,1);
    add(1,0,0,0, 48'h10, 1,0,1);
    add(1,0,1,0, 48'h10, 0,0,0);
    run("saw");

    // n_steps=0 with reserved mode 3 (behaves as single).
    cfg(48'h77, 32'h1, 24'd0, 16'd2, 2'd3);
    add(1,1,0,0, 48'h77, 1,0,0);
    add(1,0,0,0, 48'h77, 1,0,0);
    add(1,0,0,0, 48'h77, 1,0,0);
    add(1,0,0,0, 48'h77, 0,1,0);
    add(1,0,0,0, 48'h77, 0,0,0);
    run("nzero");

    // clken toggling: each value held 4 clk cycles, pulses 1 clk wide.
    cfg(48'h1000, 32'h10, 24'd3, 16'd1, 2'd0);
    add(1,1,0,0, 48'h1000, 1,0,0);
    add(0,0,0,0, 48'h1000, 1,0,0);
    add(1,0,0,0, 48'h1000, 1,0,0);
    add(0,0,0,0, 48'h1000, 1,0,0);
    add(1,0,0,0, 48'h1010, 1,0,1);
    add(0,0,0,0, 48'h1010, 1,0,0);
    add(1,0,0,0, 48'h1010, 1,0,0);
    add(0,0,0,0, 48'h1010, 1,0,0);
    add(1,0,0,0, 48'h1020, 1,0,1);
    add(0,0,0,0, 48'h1020, 1,0,0);
    add(1,0,0,0, 48'h1020, 1,0,0);
    add(0,0,0,0, 48'h1020, 1,0,0);
    add(1,0,0,0, 48'h1030, 1,0,1);
    add(0,0,0,0, 48'h1030, 1,0,0);
    add(1,0,0,0, 48'h1030, 1,0,0);
    add(0,0,0,0, 48'h1030, 1,0,0);
    add(1,0,0,0, 48'h1030, 0,1,0);
    add(0,0,0,0, 48'h1030, 0,0,0);
    run("clken");

    // Abort on the 0x1010->0x1020 step edge; then start+abort in IDLE.
    cfg(48'h1000, 32'h10, 24'd3, 16'd1, 2'd0);
    add(1,1,0,0, 48'h1000, 1,0,0);
    add(1,0,0,0, 48'h1000, 1,0,0);
    add(1,0,0,0, 48'h1010, 1,0,1);
    add(1,0,0,0, 48'h1010, 1,0,0);
    add(1,0,1,0, 48'h1010, 0,0,0);
    add(1,0,0,0, 48'h1010, 0,0,0);
    add(1,1,1,0, 48'h1010, 0,0,0);
    add(1,0,0,0, 48'h1010, 0,0,0);
    add(1,1,0,0, 48'h1000, 1,0,0);
    add(1,0,1,0, 48'h1000, 0,0,0);
    run("abort");

    // Asynchronous reset between edges, with clken low.
    cfg(48'h1000, 32'h10, 24'd3, 16'd1, 2'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("pre_rst", 48'h1010, 1, 0, 1);
    #2;
    clken   = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outs("async_rst", 48'h0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clken   = 1'b1;
    load_single();
    run("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
